// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 4-stage RISC pipeline.
//
// Owns the program counter and issues word-addressed reads to a synchronous
// instruction ROM with a 1-cycle read latency. Fetched words are presented in
// the IF/ID register with a valid bit. A 1-entry skid buffer catches the word
// that is already in flight when decode stalls. A taken branch from execute
// redirects fetch and flushes all wrong-path state.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset (0 = in reset)
//   stall_i        in   decode cannot accept; IF/ID holds
//   redirect_i     in   taken branch/jump; overrides stall_i
//   redirect_pc_i  in   branch target word address
//   imem_req_o     out  ROM read request this cycle
//   imem_addr_o    out  ROM read address
//   imem_rdata_i   in   ROM data, valid the cycle after a request
//   if_valid_o     out  IF/ID holds a live instruction
//   if_instr_o     out  IF/ID instruction
//   if_pc_o        out  IF/ID PC
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LP_ONE      = ADDR_W'(1);

  // Control state
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_skid_valid;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;

  // Data-only state (no reset needed: qualified by the control bits above)
  logic [ADDR_W-1:0]  r_inflight_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_pc;

  logic               w_issue;
  logic               w_load;
  logic               w_skid_wr;
  logic               w_skid_valid_nxt;
  logic [INSTR_W-1:0] w_load_instr;
  logic [ADDR_W-1:0]  w_load_pc;

  // Issue whenever the output will drain, or when no word is queued behind a
  // held output. The last term keeps a stalled pipe primed with one word
  // without ever having skid and in-flight occupied together.
  assign w_issue = redirect_i | ~stall_i | ~r_if_valid |
                   (~r_skid_valid & ~r_inflight);

  // A bubble in IF/ID is always overwritten, stall or not.
  assign w_load = ~stall_i | ~r_if_valid;

  // Returning word parks in the skid when the output is held, or when the
  // output is being refilled from the older skid entry.
  assign w_skid_wr = ~redirect_i & r_inflight & (~w_load | r_skid_valid);

  always_comb begin
    w_skid_valid_nxt = r_skid_valid;
    if (w_load) begin
      w_skid_valid_nxt = r_skid_valid & r_inflight;
    end else begin
      w_skid_valid_nxt = r_skid_valid | r_inflight;
    end
  end

  // Older word wins: skid content precedes the word returning now.
  assign w_load_instr = r_skid_valid ? r_skid_instr : imem_rdata_i;
  assign w_load_pc    = r_skid_valid ? r_skid_pc    : r_inflight_pc;

  assign imem_req_o  = reset & w_issue;
  assign imem_addr_o = redirect_i ? redirect_pc_i : r_fetch_pc;

  assign if_valid_o = r_if_valid;
  assign if_instr_o = r_if_instr;
  assign if_pc_o    = r_if_pc;

  // --- Issue / IF-ID boundary: PC, in-flight tracking, skid and output reg ---
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= LP_RESET_PC;
      r_inflight   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
    end else if (redirect_i) begin
      // Flush everything on the wrong path and restart at the target.
      r_if_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_inflight   <= 1'b1;
      r_fetch_pc   <= redirect_pc_i + LP_ONE;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      if (w_load) begin
        if (r_skid_valid || r_inflight) begin
          r_if_valid <= 1'b1;
          r_if_instr <= w_load_instr;
          r_if_pc    <= w_load_pc;
        end else begin
          r_if_valid <= 1'b0;
        end
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + LP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (redirect_i) begin
      r_inflight_pc <= redirect_pc_i;
    end else if (w_issue) begin
      r_inflight_pc <= r_fetch_pc;
    end
    if (w_skid_wr) begin
      r_skid_instr <= imem_rdata_i;
      r_skid_pc    <= r_inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               stall = 1'b0;
  logic               redir = 1'b0;
  logic [ADDR_W-1:0]  rpc = '0;
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata = '0;
  logic               vld;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  pc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall),
    .redirect_i   (redir),
    .redirect_pc_i(rpc),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rdata_i (rdata),
    .if_valid_o   (vld),
    .if_instr_o   (instr),
    .if_pc_o      (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a);
    return 16'h0100 + {8'h00, a};
  endfunction

  // Synchronous ROM, 1-cycle latency.
  always @(posedge clk) begin
    if (req) rdata <= rom(addr);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: a queue of fetched-but-not-presented PCs plus the
  // presented word. A PC fetched in one cycle may be presented at the end
  // of the next cycle at the earliest.
  logic [ADDR_W-1:0]  mq[$];
  logic               m_valid = 1'b0;
  logic [ADDR_W-1:0]  m_pc = '0;
  logic [INSTR_W-1:0] m_instr = '0;
  logic [ADDR_W-1:0]  m_fetch = '0;
  logic               m_req;

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_valid = 1'b0;
      m_pc    = '0;
      m_instr = '0;
      m_fetch = '0;
    end
    m_req = reset && (redir || !stall || !m_valid || mq.size() == 0);
    chk("m_req", {31'b0, req}, {31'b0, m_req});
    if (m_req) chk("m_addr", {24'b0, addr}, {24'b0, (redir ? rpc : m_fetch)});
    chk("m_valid", {31'b0, vld}, {31'b0, m_valid});
    if (m_valid || !reset) begin
      chk("m_pc", {24'b0, pc}, {24'b0, m_pc});
      chk("m_instr", {16'b0, instr}, {16'b0, m_instr});
    end
    if (reset) begin
      if (redir) begin
        mq.delete();
        mq.push_back(rpc);
        m_valid = 1'b0;
        m_fetch = rpc + 8'd1;
      end else begin
        if (!stall || !m_valid) begin
          if (mq.size() > 0) begin
            m_pc    = mq.pop_front();
            m_instr = rom(m_pc);
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
        if (m_req) begin
          mq.push_back(m_fetch);
          m_fetch = m_fetch + 8'd1;
        end
      end
    end
  end

  task automatic next(input logic s, input logic r, input logic [ADDR_W-1:0] p);
    @(posedge clk);
    #1;
    stall = s;
    redir = r;
    rpc   = p;
    #1;
  endtask

  task automatic lit_out(input string nm, input logic v, input logic [ADDR_W-1:0] p,
                         input logic [INSTR_W-1:0] ins);
    chk({nm, "_valid"}, {31'b0, vld}, {31'b0, v});
    if (v) begin
      chk({nm, "_pc"}, {24'b0, pc}, {24'b0, p});
      chk({nm, "_instr"}, {16'b0, instr}, {16'b0, ins});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, vld}, 32'd0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_pc", {24'b0, pc}, 32'd0);
    chk("rst_instr", {16'b0, instr}, 32'd0);

    // Release: first request at RESET_PC, data visible two cycles later.
    @(posedge clk); #1; reset = 1'b1; #1;
    chk("rel_req", {31'b0, req}, 32'd1);
    chk("rel_addr", {24'b0, addr}, 32'd0);
    lit_out("rel", 1'b0, 8'h00, 16'h0000);
    next(0, 0, 0); lit_out("rel1", 1'b0, 8'h00, 16'h0000);
    chk("rel1_addr", {24'b0, addr}, 32'd1);
    next(0, 0, 0); lit_out("seq0", 1'b1, 8'h00, 16'h0100);
    next(0, 0, 0); lit_out("seq1", 1'b1, 8'h01, 16'h0101);
    next(0, 0, 0); lit_out("seq2", 1'b1, 8'h02, 16'h0102);
    next(0, 0, 0); lit_out("seq3", 1'b1, 8'h03, 16'h0103);

    // Stall three cycles on PC 4; the in-flight word parks in the skid.
    next(1, 0, 0); lit_out("stl0", 1'b1, 8'h04, 16'h0104);
    chk("stl0_req", {31'b0, req}, 32'd0);
    next(1, 0, 0); lit_out("stl1", 1'b1, 8'h04, 16'h0104);
    chk("stl1_req", {31'b0, req}, 32'd0);
    next(1, 0, 0); lit_out("stl2", 1'b1, 8'h04, 16'h0104);
    chk("stl2_req", {31'b0, req}, 32'd0);
    next(0, 0, 0); lit_out("stl3", 1'b1, 8'h04, 16'h0104);
    chk("stl3_req", {31'b0, req}, 32'd1);
    chk("stl3_addr", {24'b0, addr}, 32'd6);
    next(0, 0, 0); lit_out("rls5", 1'b1, 8'h05, 16'h0105);
    next(0, 0, 0); lit_out("rls6", 1'b1, 8'h06, 16'h0106);
    next(0, 0, 0); lit_out("rls7", 1'b1, 8'h07, 16'h0107);
    next(0, 0, 0); lit_out("rls8", 1'b1, 8'h08, 16'h0108);

    // Redirect to 0x40 while PC 9 is presented.
    next(0, 1, 8'h40); lit_out("rd9", 1'b1, 8'h09, 16'h0109);
    chk("rd_addr", {24'b0, addr}, 32'h40);
    next(0, 0, 0); lit_out("rd_bub", 1'b0, 8'h00, 16'h0000);
    next(0, 0, 0); lit_out("rd40", 1'b1, 8'h40, 16'h0140);
    next(0, 0, 0); lit_out("rd41", 1'b1, 8'h41, 16'h0141);

    // Fill the skid, then redirect and stall together.
    next(1, 0, 0); lit_out("sk42", 1'b1, 8'h42, 16'h0142);
    next(1, 1, 8'h20); lit_out("skf", 1'b1, 8'h42, 16'h0142);
    chk("rs_req", {31'b0, req}, 32'd1);
    chk("rs_addr", {24'b0, addr}, 32'h20);
    next(1, 0, 0); lit_out("rs_bub", 1'b0, 8'h00, 16'h0000);
    next(0, 0, 0); lit_out("rs20", 1'b1, 8'h20, 16'h0120);
    next(0, 0, 0); lit_out("rs21", 1'b1, 8'h21, 16'h0121);

    // Redirect to the top address: fetch wraps to 0.
    next(0, 1, 8'hFF); lit_out("wr22", 1'b1, 8'h22, 16'h0122);
    next(0, 0, 0); lit_out("wr_bub", 1'b0, 8'h00, 16'h0000);
    next(0, 0, 0); lit_out("wrFF", 1'b1, 8'hFF, 16'h01FF);
    next(0, 0, 0); lit_out("wr00", 1'b1, 8'h00, 16'h0100);
    next(0, 0, 0); lit_out("wr01", 1'b1, 8'h01, 16'h0101);

    // Reset mid-run with the skid full.
    next(1, 0, 0); lit_out("mr02", 1'b1, 8'h02, 16'h0102);
    next(1, 0, 0); lit_out("mr_hold", 1'b1, 8'h02, 16'h0102);
    chk("mr_req", {31'b0, req}, 32'd0);
    reset = 1'b0; #1;
    lit_out("mr_rst", 1'b0, 8'h00, 16'h0000);
    chk("mr_rst_pc", {24'b0, pc}, 32'd0);
    chk("mr_rst_req", {31'b0, req}, 32'd0);
    @(posedge clk); #1; reset = 1'b1; stall = 1'b0; #1;
    chk("mr_rel_req", {31'b0, req}, 32'd1);
    chk("mr_rel_addr", {24'b0, addr}, 32'd0);
    next(0, 0, 0); lit_out("mr_bub", 1'b0, 8'h00, 16'h0000);
    next(0, 0, 0); lit_out("mr0", 1'b1, 8'h00, 16'h0100);
    next(0, 0, 0); lit_out("mr1", 1'b1, 8'h01, 16'h0101);
    next(0, 0, 0); lit_out("mr2", 1'b1, 8'h02, 16'h0102);

    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
